safe_mode_sequencer: RTL and testbench

Sequences safe-mode and master-core changes for the multi-core safe wrapper.
- Takes the requested configuration (safe_mode, safe_configuration, master_core, critical_section) from the safe-wrapper control registers.
- Halts all cores, applies the new configuration atomically, then resumes them.
- Outputs drive the wrapper datapath; a change is never applied while cores run or while software flags a critical section.

---
 rtl/safe_mode_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_safe_mode_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_mode_sequencer.sv
// -----------------------------------------------------------------------------
// safe_mode_sequencer
//   Sequences safe-mode / master-core changes for the multi-core safe wrapper.
//   A requested configuration that differs from the applied one halts every
//   core, is applied atomically while all cores are halted, and the cores are
//   then resumed. Nothing changes while cores run or while software holds a
//   critical section.
//
// Optional feature macro: SAFE_MODE_SEQUENCER_TIMEOUT_EN
//   Defined   : HALT/RESUME acknowledge timeout leading to a sticky ERROR state.
//   Undefined : HALT/RESUME wait indefinitely; no ERROR state.
//
// Ports
//   clk_i                    clock
//   rst_i                    synchronous active-high reset
//   safe_mode_i              requested safe mode
//   safe_configuration_i     requested safe configuration
//   master_core_i            requested master core, one-hot
//   critical_section_i       blocks starting a new sequence (sampled in IDLE)
//   core_halted_i            per-core halted status
//   halt_req_o               per-core halt request (level)
//   resume_req_o             per-core resume request (level)
//   cfg_safe_mode_o          applied safe mode
//   cfg_safe_configuration_o applied safe configuration
//   cfg_master_core_o        applied master core
//   cfg_valid_o              applied configuration stable
//   busy_o                   sequence in progress
//   done_o                   one-cycle pulse on sequence completion
//   error_o                  sticky error flag
// -----------------------------------------------------------------------------
module safe_mode_sequencer #(
    parameter int unsigned NCORES         = 3,
    parameter int unsigned CFG_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              safe_mode_i,
    input  logic              safe_configuration_i,
    input  logic [NCORES-1:0] master_core_i,
    input  logic              critical_section_i,
    input  logic [NCORES-1:0] core_halted_i,
    output logic [NCORES-1:0] halt_req_o,
    output logic [NCORES-1:0] resume_req_o,
    output logic              cfg_safe_mode_o,
    output logic              cfg_safe_configuration_o,
    output logic [NCORES-1:0] cfg_master_core_o,
    output logic              cfg_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned CFG_CNT_W = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;
    localparam logic [CFG_CNT_W-1:0] CFG_LAST   = CFG_CNT_W'(CFG_CYCLES - 1);
    localparam logic [NCORES-1:0]    ALL_ONES   = {NCORES{1'b1}};
    localparam logic [NCORES-1:0]    MASTER_RST = NCORES'(1);

    // Elaboration-time parameter sanity check.
    if (CFG_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("safe_mode_sequencer: CFG_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
    localparam int unsigned TMO_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // Configuration tuple carried from request to snapshot to applied state.
    typedef struct packed {
        logic              safe_mode;
        logic              safe_configuration;
        logic [NCORES-1:0] master_core;
    } cfg_t;

    localparam cfg_t CFG_RST = '{safe_mode: 1'b0, safe_configuration: 1'b0,
                                 master_core: MASTER_RST};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_RECONF,
        ST_RESUME
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
        , ST_ERROR
`endif
    } state_t;

    function automatic logic is_onehot(input logic [NCORES-1:0] v);
        return (v != '0) && ((v & (v - NCORES'(1))) == '0);
    endfunction

    state_t              r_state;
    state_t              w_state_next;

    cfg_t                r_snap;
    cfg_t                r_cfg;
    logic [CFG_CNT_W-1:0] r_cfg_cnt;
    logic [CFG_CNT_W-1:0] w_cfg_cnt_next;
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] r_tmo_cnt;
    logic [TMO_CNT_W-1:0] w_tmo_cnt_next;
`endif

    logic [NCORES-1:0]   r_halt_req;
    logic [NCORES-1:0]   r_resume_req;
    logic                r_cfg_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    cfg_t                w_req_cfg;
    logic                w_req;
    logic                w_snap_load;
    logic                w_cfg_load;
    logic                w_error_set;
    logic [NCORES-1:0]   w_halt_req;
    logic [NCORES-1:0]   w_resume_req;
    logic                w_cfg_valid;
    logic                w_busy;
    logic                w_done;

    assign w_req_cfg = '{safe_mode: safe_mode_i,
                         safe_configuration: safe_configuration_i,
                         master_core: master_core_i};
    assign w_req     = (r_state == ST_IDLE) && (w_req_cfg != r_cfg);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        w_state_next   = r_state;
        w_snap_load    = 1'b0;
        w_error_set    = 1'b0;
        w_cfg_cnt_next = r_cfg_cnt;
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
        w_tmo_cnt_next = r_tmo_cnt;
`endif

        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (!is_onehot(master_core_i)) begin
                        w_error_set = 1'b1;
                    end else if (!critical_section_i) begin
                        w_snap_load  = 1'b1;
                        w_state_next = ST_HALT;
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
                        w_tmo_cnt_next = '0;
`endif
                    end
                end
            end
            ST_HALT: begin
                if (core_halted_i == ALL_ONES) begin
                    w_state_next   = ST_RECONF;
                    w_cfg_cnt_next = '0;
                end
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = ST_ERROR;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + TMO_CNT_W'(1);
                end
`endif
            end
            ST_RECONF: begin
                if (r_cfg_cnt == CFG_LAST) begin
                    w_state_next = ST_RESUME;
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
                    w_tmo_cnt_next = '0;
`endif
                end else begin
                    w_cfg_cnt_next = r_cfg_cnt + CFG_CNT_W'(1);
                end
            end
            ST_RESUME: begin
                if (core_halted_i == '0) begin
                    w_state_next = ST_IDLE;
                end
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = ST_ERROR;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + TMO_CNT_W'(1);
                end
`endif
            end
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
            ST_ERROR: begin
                w_state_next = ST_ERROR;
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
        if (w_state_next == ST_ERROR) begin
            w_error_set = 1'b1;
        end
`endif

        // Outputs are decoded from the next state so they register in step with it.
        w_halt_req   = ((w_state_next == ST_HALT) || (w_state_next == ST_RECONF)) ? ALL_ONES : '0;
        w_resume_req = (w_state_next == ST_RESUME) ? ALL_ONES : '0;
        w_busy       = (w_state_next != ST_IDLE);
        w_done       = (r_state == ST_RESUME) && (w_state_next == ST_IDLE);
        w_cfg_valid  = (w_state_next != ST_RECONF);
        w_cfg_load   = (r_state == ST_HALT) && (w_state_next == ST_RECONF);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_snap       <= CFG_RST;
            r_cfg        <= CFG_RST;
            r_cfg_cnt    <= '0;
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
            r_halt_req   <= '0;
            r_resume_req <= '0;
            r_cfg_valid  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (w_snap_load) begin
                r_snap <= w_req_cfg;
            end
            // Applied configuration only changes while all cores are halted.
            if (w_cfg_load) begin
                r_cfg <= r_snap;
            end
            r_cfg_cnt    <= w_cfg_cnt_next;
`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
            r_tmo_cnt    <= w_tmo_cnt_next;
`endif
            r_halt_req   <= w_halt_req;
            r_resume_req <= w_resume_req;
            r_cfg_valid  <= w_cfg_valid;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_error      <= r_error | w_error_set;
        end
    end

    assign halt_req_o               = r_halt_req;
    assign resume_req_o             = r_resume_req;
    assign cfg_safe_mode_o          = r_cfg.safe_mode;
    assign cfg_safe_configuration_o = r_cfg.safe_configuration;
    assign cfg_master_core_o        = r_cfg.master_core;
    assign cfg_valid_o              = r_cfg_valid;
    assign busy_o                   = r_busy;
    assign done_o                   = r_done;
    assign error_o                  = r_error;

endmodule

// File: tb/tb_safe_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_safe_mode_sequencer
//   Directed self-checking bench for safe_mode_sequencer (NCORES=3,
//   CFG_CYCLES=4). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_safe_mode_sequencer;

    logic       clk_i;
    logic       rst_i;
    logic       safe_mode_i;
    logic       safe_configuration_i;
    logic [2:0] master_core_i;
    logic       critical_section_i;
    logic [2:0] core_halted_i;
    logic [2:0] halt_req_o;
    logic [2:0] resume_req_o;
    logic       cfg_safe_mode_o;
    logic       cfg_safe_configuration_o;
    logic [2:0] cfg_master_core_o;
    logic       cfg_valid_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    int n_checks = 0;
    int n_bad    = 0;

    safe_mode_sequencer #(
        .NCORES         (3),
        .CFG_CYCLES     (4),
        .TIMEOUT_CYCLES (1024)
    ) u_dut (
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .safe_mode_i              (safe_mode_i),
        .safe_configuration_i     (safe_configuration_i),
        .master_core_i            (master_core_i),
        .critical_section_i       (critical_section_i),
        .core_halted_i            (core_halted_i),
        .halt_req_o               (halt_req_o),
        .resume_req_o             (resume_req_o),
        .cfg_safe_mode_o          (cfg_safe_mode_o),
        .cfg_safe_configuration_o (cfg_safe_configuration_o),
        .cfg_master_core_o        (cfg_master_core_o),
        .cfg_valid_o              (cfg_valid_o),
        .busy_o                   (busy_o),
        .done_o                   (done_o),
        .error_o                  (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Full reset-value check on every output.
    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_halt"},   32'(halt_req_o),               32'h0);
        check_val({tag, "_resume"}, 32'(resume_req_o),             32'h0);
        check_val({tag, "_sm"},     32'(cfg_safe_mode_o),          32'h0);
        check_val({tag, "_sc"},     32'(cfg_safe_configuration_o), 32'h0);
        check_val({tag, "_mc"},     32'(cfg_master_core_o),        32'h1);
        check_val({tag, "_valid"},  32'(cfg_valid_o),              32'h1);
        check_val({tag, "_busy"},   32'(busy_o),                   32'h0);
        check_val({tag, "_done"},   32'(done_o),                   32'h0);
        check_val({tag, "_err"},    32'(error_o),                  32'h0);
    endtask

    // From a HALT cycle: acknowledge halt, wait for resume, release, wait for done.
    task automatic complete_seq(input string tag);
        int n;
        core_halted_i = 3'b111;
        n = 0;
        while (cfg_valid_o !== 1'b0 && n < 50) begin tick(1); n++; end
        check_val({tag, "_reconf_seen"}, 32'(n < 50), 32'h1);
        n = 0;
        while (resume_req_o !== 3'b111 && n < 50) begin tick(1); n++; end
        check_val({tag, "_resume_seen"}, 32'(n < 50), 32'h1);
        core_halted_i = 3'b000;
        n = 0;
        while (done_o !== 1'b1 && n < 50) begin tick(1); n++; end
        check_val({tag, "_done_seen"}, 32'(n < 50), 32'h1);
    endtask

    initial begin
        int n;
        int viol;

        rst_i                = 1'b1;
        safe_mode_i          = 1'b0;
        safe_configuration_i = 1'b0;
        master_core_i        = 3'b001;
        critical_section_i   = 1'b0;
        core_halted_i        = 3'b000;

        // Reset held two cycles.
        tick(2);
        check_reset_outputs("rst");
        rst_i = 1'b0;
        tick(1);
        check_val("idle_busy", 32'(busy_o),     32'h0);
        check_val("idle_halt", 32'(halt_req_o), 32'h0);

        // Safe-mode change: halt latency, exact reconfiguration window, resume, done.
        safe_mode_i = 1'b1;
        tick(1);
        check_val("sm_halt_n1", 32'(halt_req_o),      32'h7);
        check_val("sm_busy_n1", 32'(busy_o),          32'h1);
        check_val("sm_cfg_n1",  32'(cfg_safe_mode_o), 32'h0);
        check_val("sm_vld_n1",  32'(cfg_valid_o),     32'h1);
        tick(2);
        check_val("sm_halt_wait", 32'(halt_req_o), 32'h7);
        core_halted_i = 3'b111;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("sm_reconf%0d_vld", i),  32'(cfg_valid_o),     32'h0);
            check_val($sformatf("sm_reconf%0d_sm", i),   32'(cfg_safe_mode_o), 32'h1);
            check_val($sformatf("sm_reconf%0d_halt", i), 32'(halt_req_o),      32'h7);
            tick(1);
        end
        check_val("sm_resume_vld",  32'(cfg_valid_o),  32'h1);
        check_val("sm_resume_req",  32'(resume_req_o), 32'h7);
        check_val("sm_resume_halt", 32'(halt_req_o),   32'h0);
        tick(1);
        check_val("sm_resume_hold", 32'(resume_req_o), 32'h7);
        core_halted_i = 3'b000;
        tick(1);
        check_val("sm_done",        32'(done_o),       32'h1);
        check_val("sm_done_resume", 32'(resume_req_o), 32'h0);
        check_val("sm_done_busy",   32'(busy_o),       32'h0);
        tick(1);
        check_val("sm_done_pulse",  32'(done_o),       32'h0);
        check_val("sm_after_busy",  32'(busy_o),       32'h0);
        check_val("sm_after_cfg",   32'(cfg_safe_mode_o), 32'h1);

        // Critical section blocks a pending request.
        critical_section_i   = 1'b1;
        safe_configuration_i = 1'b1;
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (halt_req_o !== 3'b000 || busy_o !== 1'b0) viol++;
        end
        check_val("cs_blocked", 32'(viol), 32'h0);
        critical_section_i = 1'b0;
        tick(1);
        check_val("cs_release_halt", 32'(halt_req_o), 32'h7);
        critical_section_i = 1'b1;
        complete_seq("cs_seq");
        critical_section_i = 1'b0;
        check_val("cs_applied", 32'(cfg_safe_configuration_o), 32'h1);
        tick(1);

        // Non-one-hot master core: sticky error, no sequence.
        master_core_i = 3'b011;
        tick(1);
        check_val("oh_err",  32'(error_o),           32'h1);
        check_val("oh_halt", 32'(halt_req_o),        32'h0);
        check_val("oh_mc",   32'(cfg_master_core_o), 32'h1);
        tick(3);
        check_val("oh_still_idle", 32'(busy_o), 32'h0);
        master_core_i = 3'b010;
        tick(1);
        check_val("oh_fix_halt", 32'(halt_req_o), 32'h7);
        complete_seq("oh_seq");
        check_val("oh_fix_mc",  32'(cfg_master_core_o), 32'h2);
        check_val("oh_err_sticky", 32'(error_o), 32'h1);
        tick(1);

        // Input change during RECONF is ignored; second sequence follows.
        safe_mode_i = 1'b0;
        tick(1);
        check_val("chg_halt", 32'(halt_req_o), 32'h7);
        core_halted_i = 3'b111;
        tick(1);
        check_val("chg_reconf", 32'(cfg_valid_o), 32'h0);
        master_core_i = 3'b001;
        n = 0;
        while (resume_req_o !== 3'b111 && n < 50) begin tick(1); n++; end
        check_val("chg_resume_seen", 32'(n < 50), 32'h1);
        check_val("chg_mc_snap", 32'(cfg_master_core_o), 32'h2);
        check_val("chg_sm_snap", 32'(cfg_safe_mode_o),   32'h0);
        core_halted_i = 3'b000;
        n = 0;
        while (done_o !== 1'b1 && n < 50) begin tick(1); n++; end
        check_val("chg_done_seen", 32'(n < 50), 32'h1);
        check_val("chg_done_halt", 32'(halt_req_o), 32'h0);
        check_val("chg_done_mc",   32'(cfg_master_core_o), 32'h2);
        tick(1);
        check_val("chg_second_halt", 32'(halt_req_o), 32'h7);
        complete_seq("chg_seq2");
        check_val("chg_second_mc", 32'(cfg_master_core_o), 32'h1);
        tick(1);

        // Reset in the middle of a sequence.
        safe_mode_i = 1'b1;
        tick(1);
        check_val("mrst_halt", 32'(halt_req_o), 32'h7);
        core_halted_i = 3'b111;
        tick(2);
        check_val("mrst_in_reconf", 32'(cfg_valid_o), 32'h0);
        rst_i                = 1'b1;
        safe_mode_i          = 1'b0;
        safe_configuration_i = 1'b0;
        master_core_i        = 3'b001;
        tick(1);
        check_reset_outputs("mrst");
        rst_i = 1'b0;
        core_halted_i = 3'b000;
        tick(1);
        check_val("mrst_idle", 32'(busy_o), 32'h0);

`ifdef SAFE_MODE_SEQUENCER_TIMEOUT_EN
        // Halt acknowledge never arrives: ERROR after 1024 HALT cycles.
        safe_mode_i = 1'b1;
        tick(1024);
        check_val("tmo_last_halt", 32'(halt_req_o), 32'h7);
        check_val("tmo_last_err",  32'(error_o),    32'h0);
        tick(1);
        check_val("tmo_err",   32'(error_o),      32'h1);
        check_val("tmo_halt",  32'(halt_req_o),   32'h0);
        check_val("tmo_res",   32'(resume_req_o), 32'h0);
        check_val("tmo_busy",  32'(busy_o),       32'h1);
        check_val("tmo_valid", 32'(cfg_valid_o),  32'h1);
        core_halted_i = 3'b111;
        tick(10);
        check_val("tmo_frozen_busy", 32'(busy_o),     32'h1);
        check_val("tmo_frozen_halt", 32'(halt_req_o), 32'h0);
        check_val("tmo_frozen_sm",   32'(cfg_safe_mode_o), 32'h0);
        rst_i         = 1'b1;
        safe_mode_i   = 1'b0;
        core_halted_i = 3'b000;
        tick(1);
        check_reset_outputs("tmo_rst");
        rst_i = 1'b0;
        tick(1);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
